// File: rtl/pool2x2_stream.sv
// pool2x2_stream: streaming 2x2 stride-2 pooling over one feature-map channel.
// Consumes a row-major pixel stream and emits one pooled pixel per 2x2 window.
// Horizontal neighbours are paired first. Even-row pair results are parked in
// a half-row line buffer, and odd-row pairs are combined with them.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   ce         : stage enable; low freezes all state and squashes output pulses
//   in_valid   : in_data carries a pixel this cycle
//   in_data    : input pixel (unsigned, dataWidth bits)
//   out_valid  : one-cycle pulse, out_data holds a pooled pixel
//   out_data   : pooled pixel (held between pulses)
//   frame_done : one-cycle pulse with the last out_valid of a frame
module pool2x2_stream #(
  parameter int dataWidth = 16,
  parameter int m         = 8,
  parameter int n         = 8,
  parameter int ptype     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [dataWidth-1:0] in_data,
  output logic                 out_valid,
  output logic [dataWidth-1:0] out_data,
  output logic                 frame_done
);

  localparam int LBW = (m > 2) ? $clog2(m / 2) : 1;
  // col carries one extra low bit (even/odd) above the line-buffer index
  localparam int CW  = LBW + 1;
  localparam int RW  = (n > 2) ? $clog2(n) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(m - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(n - 1);

  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [dataWidth-1:0] pair_q, pair_d;
  logic                 out_valid_q, out_valid_d;
  logic [dataWidth-1:0] out_data_q, out_data_d;
  logic                 frame_done_q, frame_done_d;

  logic [dataWidth:0]   linebuf_q [m/2];
  logic                 lb_we;
  logic [LBW-1:0]       lb_idx;
  logic [dataWidth:0]   lb_rdata;

  logic                 accept;
  logic [dataWidth:0]   pair_w;
  logic [dataWidth+1:0] win_w;
  logic [dataWidth-1:0] result_w;

  always_comb begin
    accept   = ce & in_valid;
    lb_idx   = col_q[CW-1:1];
    lb_rdata = linebuf_q[lb_idx];

    // Pair and window combine; sums keep their carry bits so averaging never wraps
    if (ptype == 1) begin
      pair_w   = {1'b0, (in_data > pair_q) ? in_data : pair_q};
      win_w    = {1'b0, (lb_rdata > pair_w) ? lb_rdata : pair_w};
      result_w = win_w[dataWidth-1:0];
    end else begin
      pair_w   = {1'b0, pair_q} + {1'b0, in_data};
      win_w    = {1'b0, lb_rdata} + {1'b0, pair_w};
      result_w = win_w[dataWidth+1:2];
    end

    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    out_data_d   = out_data_q;
    lb_we        = 1'b0;

    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      if (!col_q[0]) begin
        pair_d = in_data;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_valid_d  = 1'b1;
        out_data_d   = result_w;
        frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer is not reset: each entry is written on an even row before the
  // odd row reads it. The rst_n gate keeps a reset cycle from disturbing it.
  always_ff @(posedge clk) begin
    if (rst_n && lb_we) begin
      linebuf_q[lb_idx] <= pair_w;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool2x2_stream.sv
module tb_pool2x2_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        ov_mx, fd_mx, ov_av, fd_av;
  logic [15:0] od_mx, od_av;

  always #5 clk = ~clk;

  pool2x2_stream #(.dataWidth(16), .m(4), .n(4), .ptype(1)) u_max (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_mx), .out_data(od_mx), .frame_done(fd_mx));

  pool2x2_stream #(.dataWidth(16), .m(4), .n(4), .ptype(0)) u_avg (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_av), .out_data(od_av), .frame_done(fd_av));

  typedef struct {
    logic [15:0] mx;
    logic [15:0] av;
    logic        fd;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_out = 0;
  int          n_fd = 0;
  int          cyc = 0;
  logic        ce_s = 1'b1;
  logic        rst_s = 1'b0;
  int          mc = 0;
  int          mr = 0;
  logic [15:0] img [2][4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: remembers the last two rows of the frame and, on each
  // bottom-right pixel, computes max and floor-average of the 2x2 window.
  always @(posedge clk) begin
    exp_t        e;
    logic [17:0] s;
    logic [15:0] w [4];
    cyc++;
    ce_s  = ce;
    rst_s = rst_n;
    if (!rst_n) begin
      mc = 0;
      mr = 0;
      sb.delete();
    end else if (ce && in_valid) begin
      img[mr % 2][mc] = in_data;
      if ((mr % 2 == 1) && (mc % 2 == 1)) begin
        w[0] = img[0][mc-1]; w[1] = img[0][mc];
        w[2] = img[1][mc-1]; w[3] = img[1][mc];
        e.mx = 16'h0;
        s    = 18'h0;
        for (int i = 0; i < 4; i++) begin
          if (w[i] > e.mx) e.mx = w[i];
          s = s + {2'b00, w[i]};
        end
        e.av  = s[17:2];
        e.fd  = (mr == 3) && (mc == 3);
        e.cyc = cyc;
        sb.push_back(e);
      end
      if (mc == 3) begin
        mc = 0;
        mr = (mr == 3) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_s) begin
      check("rst_valid", {30'd0, ov_mx, ov_av}, 32'd0);
      check("rst_fdone", {30'd0, fd_mx, fd_av}, 32'd0);
    end else begin
      if (!ce_s) check("stall_valid", {30'd0, ov_mx, ov_av}, 32'd0);
      check("fdone_alone", {30'd0, fd_mx & ~ov_mx, fd_av & ~ov_av}, 32'd0);
      if (ov_mx === 1'b1 || ov_av === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          n_out++;
          if (e.fd) n_fd++;
          check("valid_pair", {30'd0, ov_mx, ov_av}, 32'd3);
          check("max_data", {16'd0, od_mx}, {16'd0, e.mx});
          check("avg_data", {16'd0, od_av}, {16'd0, e.av});
          check("fdone", {30'd0, fd_mx, fd_av}, e.fd ? 32'd3 : 32'd0);
          check("latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input int gap_pct);
    while ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      step();
    end
    in_valid = 1'b1;
    in_data  = d;
    step();
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) step();
  endtask

  task automatic ramp(input int first, input int last, input int gap_pct);
    for (int i = first; i <= last; i++) send(16'(i), gap_pct);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] bnd [16];
    rst_n = 1'b0;
    step();
    step();
    check("rst_data_max", {16'd0, od_mx}, 32'd0);
    check("rst_data_avg", {16'd0, od_av}, 32'd0);
    rst_n = 1'b1;

    // Ramp frame: max 6,8,14,16 / avg 3,5,11,13
    ramp(1, 16, 0);
    idle(3);

    // Saturated frame: average must not wrap
    for (int i = 0; i < 16; i++) send(16'hFFFF, 0);
    idle(3);

    // Boundary windows: {FFFF,0001,0000,7FFF} and all-zero, the rest random
    for (int i = 0; i < 16; i++) bnd[i] = 16'($urandom);
    bnd[0] = 16'hFFFF; bnd[1] = 16'h0001; bnd[4] = 16'h0000; bnd[5] = 16'h7FFF;
    bnd[2] = 16'h0000; bnd[3] = 16'h0000; bnd[6] = 16'h0000; bnd[7] = 16'h0000;
    for (int i = 0; i < 16; i++) send(bnd[i], 0);
    idle(2);

    // Stalls: ce low for 3 cycles after pixel 7, random in_valid gaps
    ramp(1, 7, 30);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom);
      in_data  = 16'($urandom);
      step();
    end
    ce = 1'b1;
    ramp(8, 16, 30);
    idle(2);

    // Back-to-back frames
    ramp(1, 16, 0);
    ramp(1, 16, 0);
    idle(2);

    // Reset mid-frame after pixel 10, then a fresh frame
    ramp(1, 10, 0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    ramp(1, 16, 0);
    idle(2);

    // Random frames with gaps
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) send(16'($urandom), 20);
    idle(4);

    check("sb_empty", sb.size(), 32'd0);
    check("out_count", n_out, 32'd38);
    check("fdone_count", n_fd, 32'd9);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
